// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter of the multicycle MIPS core.
// Imported by the arbiter, its sub-module and the bus interface.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LD  = 1'b1
  } owner_e;

  // One-hot grant {ld, cpu}; on a tie the requester that did not win last time goes first.
  function automatic logic [1:0] rr_pick(input logic req_cpu, input logic req_ld,
                                         input owner_e last);
    logic [1:0] g;
    if (req_cpu && req_ld) begin
      g = (last == OWNER_LD) ? 2'b01 : 2'b10;
    end else begin
      g = {req_ld, req_cpu};
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_port_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_port_arbiter_pkg::DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              grant_ld;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ready, cpu_stall,
    output ld_rdata, ld_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, grant_ld
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ready, cpu_stall,
    input  ld_rdata, ld_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, grant_ld
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus the last-grant register.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant
);

  owner_e last_grant;

  assign grant = rr_pick(req[0], req[1], last_grant);

  // Reset to LD so the CPU wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWNER_LD;
    end else if (take && (grant != 2'b00)) begin
      last_grant <= grant[1] ? OWNER_LD : OWNER_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory between the CPU port and the loader/debug port with a fixed
// access latency; each completed access returns a one-cycle ready pulse to its owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
  end

  state_e            state;
  owner_e            owner;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.ld_req, bus.cpu_req}),
    .take  (state == IDLE),
    .grant (grant)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (grant[1]) begin
      sel_we    = bus.ld_we;
      sel_addr  = bus.ld_addr;
      sel_wdata = bus.ld_wdata;
    end
  end

  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ready;

  // Requester signals are latched only at grant, so later changes cannot disturb an access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWNER_CPU;
      cnt           <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.ld_ready  <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ld_rdata  <= '0;
      bus.grant_ld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner         <= grant[1] ? OWNER_LD : OWNER_CPU;
            bus.grant_ld  <= grant[1];
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            cnt           <= CNT_W'(WAIT_CYCLES - 1);
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            if (!bus.mem_we) begin
              if (owner == OWNER_LD) begin
                bus.ld_rdata <= bus.mem_rdata;
              end else begin
                bus.cpu_rdata <= bus.mem_rdata;
              end
            end
            if (owner == OWNER_LD) begin
              bus.ld_ready <= 1'b1;
            end else begin
              bus.cpu_ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          bus.cpu_ready <= 1'b0;
          bus.ld_ready  <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with WAIT_CYCLES=2: a vector table of single
// transactions plus hand-written sequences for tie ordering, latching, req drop and reset abort.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int WAIT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (DEF_ADDR_W),
    .DATA_W      (DEF_DATA_W),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [31:0] mem_rdata;
    logic        exp_ld;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_ld_rdata;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t makeVec(input string name, input logic cr, input logic cw,
                                   input logic [31:0] ca, input logic [31:0] cd,
                                   input logic lr, input logic lw,
                                   input logic [31:0] la, input logic [31:0] ld,
                                   input logic [31:0] mr, input logic eld, input logic ewe,
                                   input logic [31:0] ea, input logic [31:0] ewd,
                                   input logic [31:0] ecr, input logic [31:0] elr);
    vec_t v;
    v.name = name;       v.cpu_req = cr;      v.cpu_we = cw;
    v.cpu_addr = ca;     v.cpu_wdata = cd;    v.ld_req = lr;
    v.ld_we = lw;        v.ld_addr = la;      v.ld_wdata = ld;
    v.mem_rdata = mr;    v.exp_ld = eld;      v.exp_we = ewe;
    v.exp_addr = ea;     v.exp_wdata = ewd;   v.exp_cpu_rdata = ecr;
    v.exp_ld_rdata = elr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [199:0] act,
                             input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearReqs();
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.ld_req  = 1'b0;  bus.ld_we  = 1'b0;  bus.ld_addr  = '0;  bus.ld_wdata  = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.cpu_req = v.cpu_req;  bus.cpu_we = v.cpu_we;
    bus.cpu_addr = v.cpu_addr; bus.cpu_wdata = v.cpu_wdata;
    bus.ld_req = v.ld_req;    bus.ld_we = v.ld_we;
    bus.ld_addr = v.ld_addr;  bus.ld_wdata = v.ld_wdata;
    bus.mem_rdata = v.mem_rdata;
  endtask

  function automatic logic [199:0] allOutputs();
    return {66'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ready,
            bus.ld_ready, bus.cpu_rdata, bus.ld_rdata, bus.grant_ld, bus.cpu_stall};
  endfunction

  // One full transaction: apply, wait (bounded) for a ready pulse, then check everything seen.
  task automatic runVector(input vec_t v);
    int          en_cnt;
    int          lat;
    bit          cpu_seen;
    bit          ld_seen;
    logic [31:0] a_seen;
    logic [31:0] wd_seen;
    logic        we_seen;
    en_cnt = 0; lat = 0; cpu_seen = 0; ld_seen = 0;
    a_seen = '0; wd_seen = '0; we_seen = 1'b0;
    applyStimulus(v);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++;
        a_seen  = bus.mem_addr;
        we_seen = bus.mem_we;
        wd_seen = bus.mem_wdata;
      end
      if (bus.cpu_ready || bus.ld_ready) begin
        cpu_seen = bus.cpu_ready;
        ld_seen  = bus.ld_ready;
        lat      = c;
        break;
      end
    end
    clearReqs();
    checkOutput({v.name, " latency"}, 200'(lat), 200'(WAIT + 1));
    checkOutput({v.name, " en_cycles"}, 200'(en_cnt), 200'(WAIT));
    checkOutput({v.name, " cpu_ready"}, 200'(cpu_seen), 200'(!v.exp_ld));
    checkOutput({v.name, " ld_ready"}, 200'(ld_seen), 200'(v.exp_ld));
    checkOutput({v.name, " mem_addr"}, 200'(a_seen), 200'(v.exp_addr));
    checkOutput({v.name, " mem_we"}, 200'(we_seen), 200'(v.exp_we));
    if (v.exp_we) checkOutput({v.name, " mem_wdata"}, 200'(wd_seen), 200'(v.exp_wdata));
    checkOutput({v.name, " grant_ld"}, 200'(bus.grant_ld), 200'(v.exp_ld));
    checkOutput({v.name, " cpu_rdata"}, 200'(bus.cpu_rdata), 200'(v.exp_cpu_rdata));
    checkOutput({v.name, " ld_rdata"}, 200'(bus.ld_rdata), 200'(v.exp_ld_rdata));
    @(negedge clk);
    checkOutput({v.name, " ready_one_cycle"}, 200'({bus.cpu_ready, bus.ld_ready, bus.mem_en}),
                200'(0));
    @(negedge clk);
  endtask

  initial begin
    int          pulses;
    int          pulse_cyc[4];
    logic        pulse_ld[4];
    logic [31:0] pulse_addr[4];
    bit          got;

    vecs[0] = makeVec("cpu_read", 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 32'h8C220004,
                      0, 0, 32'h10, 32'h0, 32'h8C220004, 32'h0);
    vecs[1] = makeVec("ld_write", 0, 0, 32'h0, 32'h0, 1, 1, 32'h0, 32'h20010005, 32'hDEADBEEF,
                      1, 1, 32'h0, 32'h20010005, 32'h8C220004, 32'h0);
    vecs[2] = makeVec("ld_read", 0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 32'h12345678,
                      1, 0, 32'h40, 32'h0, 32'h8C220004, 32'h12345678);
    vecs[3] = makeVec("cpu_write", 1, 1, 32'h44, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0, 32'h55555555,
                      0, 1, 32'h44, 32'hCAFEF00D, 32'h8C220004, 32'h12345678);
    vecs[4] = makeVec("tie_after_cpu", 1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0, 32'h0BADF00D,
                      1, 0, 32'h8, 32'h0, 32'h8C220004, 32'h0BADF00D);
    vecs[5] = makeVec("tie_after_ld", 1, 0, 32'hC, 32'h0, 1, 1, 32'h1C, 32'h33, 32'hA5A5A5A5,
                      0, 0, 32'hC, 32'h0, 32'hA5A5A5A5, 32'h0BADF00D);

    clearReqs();
    bus.mem_rdata = '0;
    #12;
    checkOutput("reset_outputs", allOutputs(), 200'(0));

    // Both requesters held high straight out of reset: CPU, LD, CPU, LD every 4 cycles.
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h4;
    bus.ld_req  = 1'b1; bus.ld_addr  = 32'h8;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 40 && pulses < 4; c++) begin
      @(negedge clk);
      if (bus.cpu_ready || bus.ld_ready) begin
        pulse_cyc[pulses]  = c;
        pulse_ld[pulses]   = bus.ld_ready;
        pulse_addr[pulses] = bus.mem_addr;
        pulses++;
      end
    end
    clearReqs();
    checkOutput("rr_pulse_count", 200'(pulses), 200'(4));
    for (int i = 0; i < pulses; i++) begin
      checkOutput($sformatf("rr_owner_%0d", i), 200'(pulse_ld[i]), 200'(i % 2));
      checkOutput($sformatf("rr_addr_%0d", i), 200'(pulse_addr[i]),
                  200'((i % 2 == 1) ? 32'h8 : 32'h4));
      checkOutput($sformatf("rr_cycle_%0d", i), 200'(pulse_cyc[i]), 200'(3 + 4 * i));
    end
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 6; i++) runVector(vecs[i]);

    // CPU address/we/wdata change mid-access must not reach the memory.
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h20; bus.mem_rdata = 32'h11112222;
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        got = 1;
        break;
      end
      checkOutput($sformatf("latch_stall_%0d", c), 200'(bus.cpu_stall), 200'(1));
      checkOutput($sformatf("latch_addr_%0d", c), 200'({bus.mem_addr, bus.mem_we}),
                  200'({32'h20, 1'b0}));
      bus.cpu_addr = 32'h24; bus.cpu_we = 1'b1; bus.cpu_wdata = 32'hFFFF0000;
    end
    checkOutput("latch_ready", 200'(got), 200'(1));
    checkOutput("latch_stall_at_ready", 200'(bus.cpu_stall), 200'(0));
    checkOutput("latch_rdata", 200'(bus.cpu_rdata), 200'(32'h11112222));
    clearReqs();
    @(negedge clk);
    @(negedge clk);

    // CPU drops req one cycle after grant: still exactly one ready pulse.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'h77;
    @(negedge clk);
    checkOutput("drop_access_started", 200'({bus.mem_en, bus.mem_we}), 200'(2'b11));
    clearReqs();
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) pulses++;
    end
    checkOutput("drop_ready_pulses", 200'(pulses), 200'(1));
    checkOutput("drop_rdata_kept", 200'(bus.cpu_rdata), 200'(32'h11112222));

    // Reset in the second ACCESS cycle of a loader write: abort, no ready, CPU wins the tie after.
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h50; bus.ld_wdata = 32'h99;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_in_access", 200'({bus.mem_en, bus.grant_ld}), 200'(2'b11));
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs_zero", allOutputs(), 200'(0));
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (bus.ld_ready || bus.cpu_ready) pulses++;
    end
    checkOutput("abort_no_ready", 200'(pulses), 200'(0));
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h60;
    bus.ld_we = 1'b0; bus.ld_addr = 32'h64; bus.mem_rdata = 32'h0F0F0F0F;
    rst_n = 1'b1;
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.cpu_ready || bus.ld_ready) begin
        got = 1;
        break;
      end
    end
    checkOutput("post_reset_first_ready",
                200'({got, bus.cpu_ready, bus.ld_ready}), 200'(3'b110));
    checkOutput("post_reset_first_addr", 200'(bus.mem_addr), 200'(32'h60));
    checkOutput("post_reset_cpu_rdata", 200'(bus.cpu_rdata), 200'(32'h0F0F0F0F));
    clearReqs();
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
